apb_i2c_regbank: RTL
====================

APB_I2C_REGBANK -- requirements
Module: apb_i2c_regbank

Interface
REQ-001 SHALL have parameter DATA_W, default 32: APB data width and TX/RX data width.
REQ-002 SHALL have parameter CFG_W, default 14: width of the CONFIG and TIMEOUT registers, range 1..DATA_W.
REQ-003 SHALL have parameter TXQ_DEPTH, default 4: TX queue entries, a power of two and at least 2.
REQ-004 SHALL have ports: PCLK in 1, clock; PRESET in 1, reset, synchronous and active-high.
REQ-005 SHALL have ports: PSELx, PENABLE, PWRITE in 1; PADDR in 32; PWDATA in DATA_W: APB request.
REQ-006 SHALL have ports: PRDATA out DATA_W; PREADY out 1; PSLVERR out 1: APB response.
REQ-007 SHALL have ports: TX_DATA out DATA_W; TX_VALID out 1; TX_READY in 1: valid/ready push into the I2C core.
REQ-008 SHALL have ports: RX_DATA in DATA_W; RX_EMPTY in 1; RD_ENA out 1: RX FIFO data, empty flag and one-cycle pop.
REQ-009 SHALL have ports: ERROR in 1; INTERNAL_I2C_REGISTER_CONFIG, INTERNAL_I2C_REGISTER_TIMEOUT out CFG_W; INT_TX, INT_RX out 1.

Function
REQ-010 Access cycle: PSELx=1 and PENABLE=1; an access completes in an access cycle with PREADY=1, and side effects occur only on completion.
REQ-011 Address map: 0x0 TX (write-only), 0x4 RX (read-only), 0x8 CONFIG (RW), 0xC TIMEOUT (RW), 0x10 STATUS (only with REQ-024); any other address, or the wrong direction, is unmapped.
REQ-012 Unmapped access: PREADY=1, PSLVERR=1, PRDATA=0, no state change.
REQ-013 Write to 0x0: PREADY = !full | (TX_VALID & TX_READY); on completion PWDATA is pushed at the tail of the TX queue.
REQ-014 Queue full: wait states are inserted until a pop frees an entry; a push and pop in the same cycle leave the count unchanged.
REQ-015 TX_VALID = queue not empty; TX_DATA = head entry; pop on TX_VALID & TX_READY; pointers wrap modulo TXQ_DEPTH; the count is $clog2(TXQ_DEPTH)+1 bits wide.
REQ-016 Read of 0x4 with RX_EMPTY=0: PREADY=1, PRDATA=RX_DATA combinationally, and RD_ENA=1 for exactly that cycle.
REQ-017 Read of 0x4 with RX_EMPTY=1: PREADY=1, PSLVERR=1, PRDATA=0, RD_ENA=0.
REQ-018 Writes to 0x8 and 0xC: on completion, load PWDATA[CFG_W-1:0] into CONFIG and TIMEOUT respectively, with no wait states.
REQ-019 Reads of 0x8 and 0xC: return the register value zero-extended to DATA_W, with no wait states.
REQ-020 ERROR=1 during a completing mapped access forces PSLVERR=1; the write side effects of that access still occur.
REQ-021 RD_ENA=0 and no push occur outside completing access cycles, including while a wait state is being inserted.

Reset
REQ-022 PRESET=1 at a PCLK edge: CONFIG=0, TIMEOUT=0, TX queue empty with pointers 0, STATUS enable and sticky bits 0.
REQ-023 Reset mid-transfer: queue contents are discarded and a stalled APB write is abandoned; combinational outputs follow REQ-010..REQ-020 from the next cycle.

Configuration
REQ-024 Macro APB_I2C_STATUS_REG_EN defined: STATUS at 0x10 is mapped with these fields:
- bit0 IE_TX (RW)
- bit1 IE_RX (RW)
- bit2 ERR_STICKY: set by ERROR=1, write-1-to-clear; set wins over a same-cycle clear.
- bit3 TXQ_EMPTY (RO)
- bit4 TXQ_FULL (RO)
- bits[15:8] queue count (RO)
With the macro: INT_TX = IE_TX & queue empty; INT_RX = IE_RX & !RX_EMPTY.
REQ-025 Macro undefined: 0x10 is unmapped; INT_TX = queue empty; INT_RX = !RX_EMPTY.

Structure
REQ-026 Package apb_i2c_pkg SHALL hold the address constants (TX, RX, CONFIG, TIMEOUT, STATUS) and the STATUS bit positions.
REQ-027 The TX queue SHALL be sub-module apb_i2c_txq (parameters DATA_W, DEPTH; push, pop, full, empty and count ports).

Verification
REQ-028 Reset, then read 0x8 -> PRDATA=0, PSLVERR=0; INT_TX=1 when built without the macro.
REQ-029 Write 0x8 with 0xFFFF_ABCD -> CONFIG=14'h2BCD the next cycle; readback 0x0000_2BCD.
REQ-030 TX_READY=0, five writes to 0x0 (DEPTH 4) -> the fifth stalls with PREADY=0; raising TX_READY for 1 cycle completes it, count stays 4, head = 2nd datum.
REQ-031 RX_EMPTY=0, RX_DATA=0x55 -> read 0x4 returns 0x55, RD_ENA is a single pulse; with RX_EMPTY=1 -> PSLVERR=1, RD_ENA=0.
REQ-032 Write to 0x20 -> PSLVERR=1, no register change; ERROR=1 during a write to 0xC -> PSLVERR=1 and TIMEOUT is updated.
REQ-033 With the macro: write 0x10 with 0x3, queue empty -> INT_TX=1; ERROR pulse sets bit2; write 0x4 to 0x10 clears it.

Source files
------------

// File: rtl/apb_i2c_pkg.sv
// Shared address map and STATUS field positions for the APB-to-I2C register bank.
package apb_i2c_pkg;
  localparam logic [31:0] ADDR_TX      = 32'h00;
  localparam logic [31:0] ADDR_RX      = 32'h04;
  localparam logic [31:0] ADDR_CONFIG  = 32'h08;
  localparam logic [31:0] ADDR_TIMEOUT = 32'h0C;
  localparam logic [31:0] ADDR_STATUS  = 32'h10;

  localparam int STS_IE_TX     = 0;
  localparam int STS_IE_RX     = 1;
  localparam int STS_ERR       = 2;
  localparam int STS_TXQ_EMPTY = 3;
  localparam int STS_TXQ_FULL  = 4;
  localparam int STS_CNT_LSB   = 8;
  localparam int STS_CNT_W     = 8;

  typedef enum logic [2:0] {
    REG_NONE, REG_TX, REG_RX, REG_CONFIG, REG_TIMEOUT, REG_STATUS
  } reg_sel_e;
endpackage

// File: rtl/apb_i2c_txq.sv
// Power-of-two circular TX queue; simultaneous push and pop keep the count unchanged.
module apb_i2c_txq #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;

  always_ff @(posedge PCLK) begin
    if (push) mem[wptr] <= push_data;
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
endmodule

// File: rtl/apb_i2c_regbank.sv
// APB register bank in front of an I2C core: TX queue, RX pop, CONFIG/TIMEOUT.
// Optional STATUS register at 0x10 when APB_I2C_STATUS_REG_EN is defined.
module apb_i2c_regbank
  import apb_i2c_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CFG_W     = 14,
  parameter int TXQ_DEPTH = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSELx,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY,
  input  logic [DATA_W-1:0] RX_DATA,
  input  logic              RX_EMPTY,
  output logic              RD_ENA,
  input  logic              ERROR,
  output logic [CFG_W-1:0]  INTERNAL_I2C_REGISTER_CONFIG,
  output logic [CFG_W-1:0]  INTERNAL_I2C_REGISTER_TIMEOUT,
  output logic              INT_TX,
  output logic              INT_RX
);
  localparam int CNT_W = $clog2(TXQ_DEPTH) + 1;

  reg_sel_e         sel;
  logic             acc, done, push, pop, q_full, q_empty;
  logic [CNT_W-1:0] q_cnt;
  logic [CFG_W-1:0] cfg_q, tmo_q;

  always_comb begin
    sel = REG_NONE;
    if      (PADDR == ADDR_TX && PWRITE)  sel = REG_TX;
    else if (PADDR == ADDR_RX && !PWRITE) sel = REG_RX;
    else if (PADDR == ADDR_CONFIG)        sel = REG_CONFIG;
    else if (PADDR == ADDR_TIMEOUT)       sel = REG_TIMEOUT;
`ifdef APB_I2C_STATUS_REG_EN
    else if (PADDR == ADDR_STATUS)        sel = REG_STATUS;
`endif
  end

  assign acc      = PSELx & PENABLE;
  assign TX_VALID = !q_empty;
  assign pop      = TX_VALID & TX_READY;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign PREADY   = (sel == REG_TX) ? (!q_full | pop) : 1'b1;
  assign done     = acc & PREADY;
  assign push     = done & (sel == REG_TX);
  assign RD_ENA   = done & (sel == REG_RX) & !RX_EMPTY;

  apb_i2c_txq #(.DATA_W(DATA_W), .DEPTH(TXQ_DEPTH)) u_txq (
    .PCLK(PCLK), .PRESET(PRESET), .push(push), .push_data(PWDATA), .pop(pop),
    .head(TX_DATA), .full(q_full), .empty(q_empty), .count(q_cnt)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cfg_q <= '0;
      tmo_q <= '0;
    end else if (done && PWRITE) begin
      if (sel == REG_CONFIG)  cfg_q <= PWDATA[CFG_W-1:0];
      if (sel == REG_TIMEOUT) tmo_q <= PWDATA[CFG_W-1:0];
    end
  end

  assign INTERNAL_I2C_REGISTER_CONFIG  = cfg_q;
  assign INTERNAL_I2C_REGISTER_TIMEOUT = tmo_q;

`ifdef APB_I2C_STATUS_REG_EN
  logic              ie_tx, ie_rx, err_sticky, sts_wr;
  logic [DATA_W-1:0] sts_rd;

  assign sts_wr = done & PWRITE & (sel == REG_STATUS);

  // A same-cycle ERROR beats the write-1-to-clear.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ie_tx      <= 1'b0;
      ie_rx      <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (sts_wr) begin
        ie_tx <= PWDATA[STS_IE_TX];
        ie_rx <= PWDATA[STS_IE_RX];
      end
      if (ERROR)                           err_sticky <= 1'b1;
      else if (sts_wr && PWDATA[STS_ERR])  err_sticky <= 1'b0;
    end
  end

  always_comb begin
    sts_rd                           = '0;
    sts_rd[STS_IE_TX]                = ie_tx;
    sts_rd[STS_IE_RX]                = ie_rx;
    sts_rd[STS_ERR]                  = err_sticky;
    sts_rd[STS_TXQ_EMPTY]            = q_empty;
    sts_rd[STS_TXQ_FULL]             = q_full;
    sts_rd[STS_CNT_LSB +: CNT_W]     = q_cnt;
  end

  assign INT_TX = ie_tx & q_empty;
  assign INT_RX = ie_rx & !RX_EMPTY;
`else
  assign INT_TX = q_empty;
  assign INT_RX = !RX_EMPTY;
`endif

  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (acc) begin
      case (sel)
        REG_NONE:    PSLVERR = 1'b1;
        REG_RX:      if (RX_EMPTY) PSLVERR = 1'b1; else PRDATA = RX_DATA;
        REG_CONFIG:  if (!PWRITE) PRDATA = DATA_W'(cfg_q);
        REG_TIMEOUT: if (!PWRITE) PRDATA = DATA_W'(tmo_q);
`ifdef APB_I2C_STATUS_REG_EN
        REG_STATUS:  if (!PWRITE) PRDATA = sts_rd;
`endif
        default: ;
      endcase
      if (PREADY && sel != REG_NONE && ERROR) PSLVERR = 1'b1;
    end
  end
endmodule
